mem_wb_reg: RTL

MEM_WB_REG -- requirements
Module: mem_wb_reg

---
 rtl/mem_wb_pkg.sv | 13 +
 rtl/mem_wb_if.sv | 32 +++
 rtl/mem_wb_skid.sv | 106 ++++++++++
 rtl/mem_wb_reg.sv | 56 +++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types and default widths for the MEM/WB pipeline register.
package mem_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/mem_wb_if.sv
// MEM-side and WB-side handshake/data bundle around the MEM/WB pipeline register.
interface mem_wb_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [DATA_W-1:0] mem_op_c_i;
  logic [ADDR_W-1:0] mem_reg_waddr_i;
  logic              mem_reg_we_i;

  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [DATA_W-1:0] wb_op_c_o;
  logic [ADDR_W-1:0] wb_reg_waddr_o;
  logic              wb_reg_we_o;

  // The pipeline register itself sits on the slave side.
  modport slave (
    input  mem_valid_i, mem_op_c_i, mem_reg_waddr_i, mem_reg_we_i, wb_ready_i,
    output mem_ready_o, wb_valid_o, wb_op_c_o, wb_reg_waddr_o, wb_reg_we_o
  );

  modport master (
    output mem_valid_i, mem_op_c_i, mem_reg_waddr_i, mem_reg_we_i, wb_ready_i,
    input  mem_ready_o, wb_valid_o, wb_op_c_o, wb_reg_waddr_o, wb_reg_we_o
  );

endinterface

// File: rtl/mem_wb_skid.sv
// Two-entry (main + skid) storage with a registered ready, so upstream ready
// never depends combinationally on downstream ready.
module mem_wb_skid
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_op_c,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_c,
  output logic [ADDR_W-1:0] out_waddr,
  output logic              out_we
);

  wb_state_e         state_q, state_n;
  logic              ready_q;
  logic [DATA_W-1:0] main_op_c_q, skid_op_c_q;
  logic [ADDR_W-1:0] main_waddr_q, skid_waddr_q;
  logic              main_we_q, skid_we_q;

  logic accept, retire;
  logic load_main, skid_to_main, load_skid;

  assign accept    = in_valid & ready_q;
  assign retire    = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = ready_q;
  assign out_op_c  = main_op_c_q;
  assign out_waddr = main_waddr_q;
  assign out_we    = main_we_q;

  // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n      = state_q;
    load_main    = 1'b0;
    skid_to_main = 1'b0;
    load_skid    = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_n   = BUSY;
          load_main = 1'b1;
        end
        BUSY: begin
          if (accept && retire) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (retire) begin
            state_n = EMPTY;
          end
        end
        FULL: if (retire) begin
          state_n      = BUSY;
          skid_to_main = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // NOTE: the data entries are reset too, so WB outputs read zero during reset rather than stale values.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so main <- skid is race-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      ready_q      <= 1'b1;
      main_op_c_q  <= '0;
      main_waddr_q <= '0;
      main_we_q    <= 1'b0;
      skid_op_c_q  <= '0;
      skid_waddr_q <= '0;
      skid_we_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      ready_q <= (state_n != FULL);
      if (load_main) begin
        main_op_c_q  <= in_op_c;
        main_waddr_q <= in_waddr;
        main_we_q    <= in_we;
      end else if (skid_to_main) begin
        main_op_c_q  <= skid_op_c_q;
        main_waddr_q <= skid_waddr_q;
        main_we_q    <= skid_we_q;
      end
      if (load_skid) begin
        skid_op_c_q  <= in_op_c;
        skid_waddr_q <= in_waddr;
        skid_we_q    <= in_we;
      end
    end
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: skid storage, x0 write suppression and a retire counter.
module mem_wb_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  mem_wb_if.slave     bus,
  output logic [31:0] retire_cnt_o
);

  logic              wb_valid;
  logic              main_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_op_c;
  logic              mem_ready;
  logic [31:0]       retire_cnt_q;

  mem_wb_skid #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_i),
    .in_valid (bus.mem_valid_i),
    .in_ready (mem_ready),
    .in_op_c  (bus.mem_op_c_i),
    .in_waddr (bus.mem_reg_waddr_i),
    .in_we    (bus.mem_reg_we_i),
    .out_valid(wb_valid),
    .out_ready(bus.wb_ready_i),
    .out_op_c (wb_op_c),
    .out_waddr(wb_waddr),
    .out_we   (main_we)
  );

  assign bus.mem_ready_o    = mem_ready;
  assign bus.wb_valid_o     = wb_valid;
  assign bus.wb_op_c_o      = wb_op_c;
  assign bus.wb_reg_waddr_o = wb_waddr;
  // x0 is hardwired to zero, so writes to it never reach the register file.
  assign bus.wb_reg_we_o    = wb_valid & main_we & (wb_waddr != '0);

  // A retire in a flush cycle is already committed, so flush does not gate it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt_q <= '0;
    else if (wb_valid && bus.wb_ready_i) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign retire_cnt_o = retire_cnt_q;

endmodule
